mul12_err_monitor: RTL
======================

Name: mul12_err_monitor

Overview:
Sequential error-statistics stage that sits directly downstream of the 12x12 approximate unsigned multipliers. It consumes each operand pair and the approximate 24-bit product O, and recomputes the exact product with an internal 12-step shift-add multiplier. Over a programmed window of samples it accumulates sum of absolute error, worst-case error with its operands, and erroneous-sample count. These are the on-chip MAE/WCE/EP figures used to characterise a candidate multiplier on FPGA.

Parameters:
CNT_W, 16, width of the sample-count window and err_count.
ACC_W, 40, width of sum_abs_err; must be >= 24+CNT_W, so no overflow or saturation is possible.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  one-cycle request to clear statistics and open a window; honoured only in IDLE.
num_samples  in  CNT_W  window length, sampled on an honoured start.
in_valid  in  1  sample offered.
in_ready  out  1  high only in ACCEPT.
in_a  in  12  operand A fed to the multiplier.
in_b  in  12  operand B fed to the multiplier.
in_o  in  24  approximate product O from the multiplier.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse when the window completes.
sum_abs_err  out  ACC_W  running sum of |exact - O|.
max_abs_err  out  24  largest |exact - O| in the window.
max_err_a  out  12  in_a of the first sample reaching max_abs_err.
max_err_b  out  12  in_b of the first sample reaching max_abs_err.
err_count  out  CNT_W  number of samples with nonzero error.

Behaviour:
- Clock is clk; reset is rst, asynchronous and active-high. On reset all outputs and internal registers go to 0 and the FSM goes to IDLE.
- FSM states: IDLE, ACCEPT, MUL, UPDATE, DONE.
- IDLE:
  - start with num_samples!=0: clear all statistics, load remaining=num_samples, go to ACCEPT.
  - start with num_samples==0: clear statistics, then pulse done the next cycle; busy stays 0.
- ACCEPT: in_ready=1. On in_valid&in_ready, capture a, b, o; clear the product register and step counter; go to MUL. in_valid low means wait indefinitely.
- MUL: exactly 12 cycles. Each cycle: if b_sh[0], prod += a_sh (24-bit); a_sh <<= 1; b_sh >>= 1. After step 11, go to UPDATE.
- UPDATE, single cycle:
  - err = (prod >= o) ? prod-o : o-prod. This is unsigned 24-bit; an approximate result above the exact product is legal.
  - sum_abs_err += err.
  - If err > max_abs_err (strictly greater), load max_abs_err, max_err_a and max_err_b. Ties keep the earlier sample.
  - If err != 0, increment err_count.
  - remaining -= 1. Go to DONE if the new value is 0, else to ACCEPT.
- DONE: done=1 for exactly one cycle, then IDLE.
- Statistics hold their values until the next honoured start or reset.
- Timing: handshake at edge k, MUL edges k+1..k+12, statistics updated at edge k+13.
  - Back-to-back sustained rate is one sample per 14 cycles.
  - done is high in the cycle after the last update.
- start outside IDLE is ignored, with no effect on statistics or remaining.
- in_a, in_b and in_o may change freely after the handshake; only the captured copies are used.
- Reset asserted mid-window (any state) aborts immediately: no done pulse, statistics zeroed.

Test Plan:
1. Assert rst, then release -> all outputs 0, in_ready=0, busy=0, FSM in IDLE.
2. start, num_samples=1; sample a=0xFFF, b=0xFFF, o=0xFFE001 -> sum=0, max=0, err_count=0; done pulses 14 cycles after the handshake edge.
3. start, num_samples=3; samples:
   - (0x800, 0x800, o=0), error 4194304.
   - (3, 5, o=0), error 15.
   - (1, 1, o=0x000100), approx above exact, error 255.
   -> sum=4194574, max=0x400000, max_err_a=0x800, max_err_b=0x800, err_count=3.
4. start, num_samples=2; samples (2, 2, o=0) and (1, 4, o=0), both error 4 -> max=4, max_err_a=2, max_err_b=2 (first sample kept on tie), err_count=2.
5. Stall and edge cases:
   - Hold in_valid=0 for 20 cycles in ACCEPT -> in_ready stays 1 and nothing is captured.
   - Pulse start while in MUL -> ignored, remaining unchanged.
   - start with num_samples=0 from IDLE -> done pulses next cycle and statistics read 0.
6. Assert rst during the MUL of the 2nd of 3 samples -> all outputs 0 immediately and no done pulse. A fresh start with num_samples=1 afterwards completes normally.

Source files
------------

// File: rtl/mul12_err_monitor.sv
// Error-statistics monitor for a 12x12 approximate multiplier: recomputes the exact product
// with a 12-step shift-add and accumulates sum/max of |exact - O| plus the erroneous-sample count.
module mul12_err_monitor #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned ACC_W = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [11:0]      in_a,
  input  logic [11:0]      in_b,
  input  logic [23:0]      in_o,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] sum_abs_err,
  output logic [23:0]      max_abs_err,
  output logic [11:0]      max_err_a,
  output logic [11:0]      max_err_b,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [2:0] {StIdle, StAccept, StMul, StUpdate, StDone} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] remaining_q;
  logic [11:0]      a_q, b_q, b_sh_q;
  logic [23:0]      a_sh_q, o_q, prod_q;
  logic [3:0]       step_q;
  logic             zero_done_q;
  logic [23:0]      err;

  assign err = (prod_q >= o_q) ? (prod_q - o_q) : (o_q - prod_q);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start && (num_samples != '0)) state_d = StAccept;
      StAccept: if (in_valid) state_d = StMul;
      StMul:    if (step_q == 4'd11) state_d = StUpdate;
      StUpdate: state_d = (remaining_q == CNT_W'(1)) ? StDone : StAccept;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  assign in_ready = (state_q == StAccept);
  assign busy     = (state_q != StIdle);
  // An empty window pulses done from IDLE so that busy never rises.
  assign done     = (state_q == StDone) || zero_done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      a_q         <= '0;
      b_q         <= '0;
      b_sh_q      <= '0;
      a_sh_q      <= '0;
      o_q         <= '0;
      prod_q      <= '0;
      step_q      <= '0;
      zero_done_q <= 1'b0;
      sum_abs_err <= '0;
      max_abs_err <= '0;
      max_err_a   <= '0;
      max_err_b   <= '0;
      err_count   <= '0;
    end else begin
      state_q     <= state_d;
      zero_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            sum_abs_err <= '0;
            max_abs_err <= '0;
            max_err_a   <= '0;
            max_err_b   <= '0;
            err_count   <= '0;
            remaining_q <= num_samples;
            zero_done_q <= (num_samples == '0);
          end
        end
        StAccept: begin
          if (in_valid) begin
            a_q    <= in_a;
            b_q    <= in_b;
            o_q    <= in_o;
            a_sh_q <= {12'd0, in_a};
            b_sh_q <= in_b;
            prod_q <= '0;
            step_q <= '0;
          end
        end
        StMul: begin
          if (b_sh_q[0]) prod_q <= prod_q + a_sh_q;
          a_sh_q <= a_sh_q << 1;
          b_sh_q <= b_sh_q >> 1;
          step_q <= step_q + 4'd1;
        end
        StUpdate: begin
          sum_abs_err <= sum_abs_err + ACC_W'(err);
          // Strict compare: ties keep the earlier sample's operands.
          if (err > max_abs_err) begin
            max_abs_err <= err;
            max_err_a   <= a_q;
            max_err_b   <= b_q;
          end
          if (err != '0) err_count <= err_count + CNT_W'(1);
          remaining_q <= remaining_q - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
